// File: rtl/veggie_scheduler.sv
// veggie_scheduler: once-per-frame spawn / flight / split / retire control for the veggie sprite pair.
// Build option VEGGIE_SCHED_WALL_BOUNCE_EN: a half reaching a side wall reverses its vx instead of stopping.
module veggie_scheduler #(
    parameter int SCREEN_W       = 1024,
    parameter int SCREEN_H       = 768,
    parameter int VEG_W          = 128,
    parameter int VEG_H          = 128,
    parameter int LAUNCH_VY      = 24,
    parameter int GRAVITY        = 1,
    parameter int SPLIT_VX       = 4,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_done_in,
    input  logic        hit_in,
    input  logic [15:0] random_in,
    output logic [10:0] top_x_out,
    output logic [9:0]  top_y_out,
    output logic [10:0] bottom_x_out,
    output logic [9:0]  bottom_y_out,
    output logic        visible_out,
    output logic        split_out,
    output logic        slice_pulse_out,
    output logic        miss_pulse_out,
    output logic        veggie_gone_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_SPLIT  = 2'd2
    } state_t;

    localparam logic signed [11:0] Y_LIMIT     = 12'(SCREEN_H);
    localparam logic signed [11:0] X_MAX       = 12'(SCREEN_W - VEG_W);
    localparam logic signed [11:0] TOP_SPAWN_Y = 12'(SCREEN_H - VEG_H);
    localparam logic signed [11:0] BOT_SPAWN_Y = 12'(SCREEN_H - VEG_H + VEG_H / 2);
    localparam logic signed [6:0]  VY_CAP      = 7'(LAUNCH_VY);
    localparam logic [6:0]         GRAV7       = 7'(GRAVITY);
    localparam logic signed [5:0]  VY_LAUNCH   = 6'(-LAUNCH_VY);
    localparam logic signed [5:0]  VX_SPLIT    = 6'(SPLIT_VX);
    localparam logic [5:0]         RELOAD      = 6'(RESPAWN_FRAMES);
    localparam logic [9:0]         X_SPAN      = 10'(SCREEN_W - VEG_W);

    // Frame contract: frame_done_in is a strobe, one frame per high cycle; nothing
    // else moves the state, and hit_in is only looked at in a cycle with the strobe.

    state_t             state_q, state_d;
    logic [5:0]         count_q, count_d;
    logic signed [11:0] top_x_q, top_x_d, top_y_q, top_y_d;
    logic signed [11:0] bot_x_q, bot_x_d, bot_y_q, bot_y_d;
    logic signed [5:0]  top_vx_q, top_vx_d, bot_vx_q, bot_vx_d;
    logic signed [5:0]  vy_q, vy_d;
    logic               visible_q, visible_d, split_q, split_d;
    logic               slice_q, slice_d, miss_q, miss_d, gone_q, gone_d;

    logic signed [11:0] vy_ext, top_vx_ext, bot_vx_ext;
    logic signed [11:0] top_y_mv, bot_y_mv, top_x_mv, bot_x_mv;
    logic signed [11:0] top_y_cl, bot_y_cl, top_x_cl, bot_x_cl;
    logic signed [5:0]  top_vx_w, bot_vx_w;
    logic signed [6:0]  vy_sum;
    logic signed [5:0]  vy_mv;
    logic [9:0]         spawn_r;
    logic [11:0]        spawn_x;
    logic [5:0]         spawn_mag;
    logic [5:0]         spawn_vx;
    logic               top_out, bot_out;
    logic               unused_random;

    assign unused_random = ^random_in[15:13];

    function automatic logic signed [11:0] wall_clamp_x(input logic signed [11:0] x);
        if (x < 12'sd0) begin
            return 12'sd0;
        end else if (x > X_MAX) begin
            return X_MAX;
        end
        return x;
    endfunction

    function automatic logic signed [5:0] wall_vx(input logic signed [11:0] x,
                                                  input logic signed [5:0]  vx);
        if ((x < 12'sd0) || (x > X_MAX)) begin
`ifdef VEGGIE_SCHED_WALL_BOUNCE_EN
            return -vx;
`else
            return 6'sd0;
`endif
        end
        return vx;
    endfunction

    // Candidate motion for this frame, always computed from the pre-update position.
    always_comb begin
        vy_ext     = {{6{vy_q[5]}}, vy_q};
        top_vx_ext = {{6{top_vx_q[5]}}, top_vx_q};
        bot_vx_ext = {{6{bot_vx_q[5]}}, bot_vx_q};

        top_y_mv = top_y_q + vy_ext;
        bot_y_mv = bot_y_q + vy_ext;
        top_x_mv = top_x_q + top_vx_ext;
        bot_x_mv = bot_x_q + bot_vx_ext;

        top_y_cl = (top_y_mv < 12'sd0) ? 12'sd0 : top_y_mv;
        bot_y_cl = (bot_y_mv < 12'sd0) ? 12'sd0 : bot_y_mv;
        top_x_cl = wall_clamp_x(top_x_mv);
        bot_x_cl = wall_clamp_x(bot_x_mv);
        top_vx_w = wall_vx(top_x_mv, top_vx_q);
        bot_vx_w = wall_vx(bot_x_mv, bot_vx_q);

        vy_sum = {vy_q[5], vy_q} + GRAV7;
        vy_mv  = (vy_sum > VY_CAP) ? VY_CAP[5:0] : vy_sum[5:0];
        if ((top_y_mv < 12'sd0) || (bot_y_mv < 12'sd0)) begin
            vy_mv = 6'sd0;
        end

        top_out = (top_y_cl >= Y_LIMIT);
        bot_out = (bot_y_cl >= Y_LIMIT);
    end

    // Spawn column folds the upper random range back onto the screen.
    always_comb begin
        spawn_r   = random_in[9:0];
        spawn_x   = (spawn_r >= X_SPAN) ? {2'b00, spawn_r - X_SPAN} : {2'b00, spawn_r};
        spawn_mag = {4'b0000, random_in[11:10]};
        spawn_vx  = random_in[12] ? (6'd0 - spawn_mag) : spawn_mag;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        top_x_d   = top_x_q;
        top_y_d   = top_y_q;
        bot_x_d   = bot_x_q;
        bot_y_d   = bot_y_q;
        top_vx_d  = top_vx_q;
        bot_vx_d  = bot_vx_q;
        vy_d      = vy_q;
        visible_d = visible_q;
        split_d   = split_q;
        slice_d   = 1'b0;
        miss_d    = 1'b0;
        gone_d    = 1'b0;

        if (frame_done_in) begin
            case (state_q)
                ST_WAIT: begin
                    if (count_q != 6'd0) begin
                        count_d = count_q - 6'd1;
                    end else begin
                        state_d   = ST_FLIGHT;
                        visible_d = 1'b1;
                        top_x_d   = spawn_x;
                        bot_x_d   = spawn_x;
                        top_y_d   = TOP_SPAWN_Y;
                        bot_y_d   = BOT_SPAWN_Y;
                        vy_d      = VY_LAUNCH;
                        top_vx_d  = spawn_vx;
                        bot_vx_d  = spawn_vx;
                    end
                end
                ST_FLIGHT, ST_SPLIT: begin
                    top_x_d  = top_x_cl;
                    bot_x_d  = bot_x_cl;
                    top_y_d  = top_y_cl;
                    bot_y_d  = bot_y_cl;
                    top_vx_d = top_vx_w;
                    bot_vx_d = bot_vx_w;
                    vy_d     = vy_mv;
                    if (state_q == ST_FLIGHT) begin
                        // A hit in the same frame as the exit still counts as a slice.
                        if (hit_in) begin
                            state_d  = ST_SPLIT;
                            split_d  = 1'b1;
                            slice_d  = 1'b1;
                            top_vx_d = top_vx_w - VX_SPLIT;
                            bot_vx_d = bot_vx_w + VX_SPLIT;
                        end else if (top_out) begin
                            state_d   = ST_WAIT;
                            count_d   = RELOAD;
                            visible_d = 1'b0;
                            miss_d    = 1'b1;
                            gone_d    = 1'b1;
                        end
                    end else if (top_out && bot_out) begin
                        state_d   = ST_WAIT;
                        count_d   = RELOAD;
                        visible_d = 1'b0;
                        split_d   = 1'b0;
                        gone_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    count_d = RELOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_WAIT;
            count_q   <= RELOAD;
            top_x_q   <= 12'sd0;
            bot_x_q   <= 12'sd0;
            top_y_q   <= Y_LIMIT;
            bot_y_q   <= Y_LIMIT;
            top_vx_q  <= 6'sd0;
            bot_vx_q  <= 6'sd0;
            vy_q      <= 6'sd0;
            visible_q <= 1'b0;
            split_q   <= 1'b0;
            slice_q   <= 1'b0;
            miss_q    <= 1'b0;
            gone_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            top_x_q   <= top_x_d;
            bot_x_q   <= bot_x_d;
            top_y_q   <= top_y_d;
            bot_y_q   <= bot_y_d;
            top_vx_q  <= top_vx_d;
            bot_vx_q  <= bot_vx_d;
            vy_q      <= vy_d;
            visible_q <= visible_d;
            split_q   <= split_d;
            slice_q   <= slice_d;
            miss_q    <= miss_d;
            gone_q    <= gone_d;
        end
    end

    assign top_x_out       = top_x_q[10:0];
    assign top_y_out       = top_y_q[9:0];
    assign bottom_x_out    = bot_x_q[10:0];
    assign bottom_y_out    = bot_y_q[9:0];
    assign visible_out     = visible_q;
    assign split_out       = split_q;
    assign slice_pulse_out = slice_q;
    assign miss_pulse_out  = miss_q;
    assign veggie_gone_out = gone_q;
    assign state_out       = state_q;

endmodule
